// File: rtl/datapath_control_unit.sv
// Hard-wired Moore control unit for the single-bus datapath.
// Sequences fetch (T0-T2) and execute (T3-T7), decodes the latched opcode,
// and handles run/halt. Every output is a function of state and opcode only.
module datapath_control_unit #(
  parameter logic [4:0] OP_LD   = 5'b00000,
  parameter logic [4:0] OP_LDI  = 5'b00001,
  parameter logic [4:0] OP_ST   = 5'b00010,
  parameter logic [4:0] OP_ADD  = 5'b00011,
  parameter logic [4:0] OP_SUB  = 5'b00100,
  parameter logic [4:0] OP_NOP  = 5'b11010,
  parameter logic [4:0] OP_HALT = 5'b11011,
  parameter logic [4:0] ALU_ADD = 5'b00001,
  parameter logic [4:0] ALU_SUB = 5'b00010
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run_req,
  input  logic [31:0] IR_Data,
  output logic        PC_select,
  output logic        MAR_enable,
  output logic        PC_increment_enable,
  output logic        read,
  output logic        MDR_enable,
  output logic        MDR_select,
  output logic        IR_enable,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        BAout,
  output logic        r_out,
  output logic        r_enable,
  output logic        Y_enable,
  output logic        Z_enable,
  output logic        c_select,
  output logic        Z_LO_select,
  output logic        write,
  output logic [4:0]  alu_instruction,
  output logic        running,
  output logic        illegal_op
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALTED
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [4:0] opcode;

  logic is_ld, is_ldi, is_st, is_add, is_sub, is_nop, is_halt;
  logic is_addr_calc, is_reg_alu, is_legal;
  logic unused_ir_bits;

  // Only the opcode field of the instruction matters to the control unit.
  assign unused_ir_bits = ^IR_Data[26:0];

  assign is_ld        = (opcode == OP_LD);
  assign is_ldi       = (opcode == OP_LDI);
  assign is_st        = (opcode == OP_ST);
  assign is_add       = (opcode == OP_ADD);
  assign is_sub       = (opcode == OP_SUB);
  assign is_nop       = (opcode == OP_NOP);
  assign is_halt      = (opcode == OP_HALT);
  assign is_addr_calc = is_ld | is_ldi | is_st;
  assign is_reg_alu   = is_add | is_sub;
  assign is_legal     = is_addr_calc | is_reg_alu | is_nop | is_halt;

  // State register; reset parks the machine in IDLE from any state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // Opcode latch, loaded on the T2->T3 edge so execute ignores later IR changes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            opcode <= OP_NOP;
    else if (state == S_T2)  opcode <= IR_Data[31:27];
  end

  // Next-state logic; run_req is only sampled at instruction boundaries.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:   next_state = run_req ? S_T0 : S_IDLE;
      S_T0:     next_state = S_T1;
      S_T1:     next_state = S_T2;
      S_T2:     next_state = S_T3;
      S_T3: begin
        if (is_halt)                        next_state = S_HALTED;
        else if (is_addr_calc | is_reg_alu) next_state = S_T4;
        else                                next_state = run_req ? S_T0 : S_IDLE;
      end
      S_T4:     next_state = S_T5;
      S_T5: begin
        if (is_ld | is_st) next_state = S_T6;
        else               next_state = run_req ? S_T0 : S_IDLE;
      end
      S_T6:     next_state = S_T7;
      S_T7:     next_state = run_req ? S_T0 : S_IDLE;
      S_HALTED: next_state = S_HALTED;
      default:  next_state = S_IDLE;
    endcase
  end

  // Moore output decode from the current state and the latched opcode.
  always_comb begin
    PC_select           = 1'b0;
    MAR_enable          = 1'b0;
    PC_increment_enable = 1'b0;
    read                = 1'b0;
    MDR_enable          = 1'b0;
    MDR_select          = 1'b0;
    IR_enable           = 1'b0;
    Gra                 = 1'b0;
    Grb                 = 1'b0;
    Grc                 = 1'b0;
    BAout               = 1'b0;
    r_out               = 1'b0;
    r_enable            = 1'b0;
    Y_enable            = 1'b0;
    Z_enable            = 1'b0;
    c_select            = 1'b0;
    Z_LO_select         = 1'b0;
    write               = 1'b0;
    alu_instruction     = 5'b00000;
    illegal_op          = 1'b0;
    running             = (state != S_IDLE) && (state != S_HALTED);
    case (state)
      S_T0: begin
        PC_select  = 1'b1;
        MAR_enable = 1'b1;
      end
      S_T1: begin
        PC_increment_enable = 1'b1;
        read                = 1'b1;
        MDR_enable          = 1'b1;
      end
      S_T2: begin
        MDR_select = 1'b1;
        IR_enable  = 1'b1;
      end
      S_T3: begin
        if (is_addr_calc) begin
          Grb      = 1'b1;
          BAout    = 1'b1;
          Y_enable = 1'b1;
        end else if (is_reg_alu) begin
          Grb      = 1'b1;
          r_out    = 1'b1;
          Y_enable = 1'b1;
        end
        illegal_op = !is_legal;
      end
      S_T4: begin
        Z_enable = 1'b1;
        if (is_reg_alu) begin
          Grc             = 1'b1;
          r_out           = 1'b1;
          alu_instruction = is_sub ? ALU_SUB : ALU_ADD;
        end else if (is_addr_calc) begin
          c_select        = 1'b1;
          alu_instruction = ALU_ADD;
        end
      end
      S_T5: begin
        Z_LO_select = 1'b1;
        if (is_ld | is_st) begin
          MAR_enable = 1'b1;
        end else begin
          Gra      = 1'b1;
          r_enable = 1'b1;
        end
      end
      S_T6: begin
        MDR_enable = 1'b1;
        if (is_st) begin
          Gra   = 1'b1;
          r_out = 1'b1;
        end else begin
          read = 1'b1;
        end
      end
      S_T7: begin
        if (is_st) begin
          write = 1'b1;
        end else begin
          MDR_select = 1'b1;
          Gra        = 1'b1;
          r_enable   = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
